// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

    localparam int unsigned PC_W        = 9;
    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned FETCH_DEPTH = 4;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        pc_t    pc;
    } fetch_entry_t;

    // Relative branch target; the 9-bit add wraps modulo 512.
    function automatic pc_t branch_target(input pc_t base, input pc_t offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue: push at tail, pop at head, flush empties it.
// The head entry is read straight from registered storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output fetch_entry_t             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch into a small queue, with branch redirect/flush.
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_cnt output.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = FETCH_DEPTH,
    parameter pc_t         RESET_PC = 9'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_W-1:0]   instr,
    output logic [PC_W-1:0]      instr_pc,
    input  logic                 br_taken,
    input  logic [PC_W-1:0]      br_pc,
    input  logic [PC_W-1:0]      br_offset
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    pc_t                   fetch_pc_q;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t          head;
    fetch_entry_t          tail_entry;

    assign pop  = instr_valid && instr_ready;
    // A pop in the same cycle frees a slot, so a full queue still streams.
    assign push = !br_taken && (!full || pop);

    assign tail_entry.instr = imem_data;
    assign tail_entry.pc    = fetch_pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (tail_entry),
        .pop       (pop),
        .flush     (br_taken),
        .count     (count),
        .full      (full),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else if (br_taken) begin
            fetch_pc_q <= branch_target(br_pc, br_offset);
        end else if (push) begin
            fetch_pc_q <= fetch_pc_q + pc_t'(1);
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!instr_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 9'd0, meaning first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_addr, output, 9, instruction memory address, equal to fetch_pc.
REQ-006 SHALL have port imem_data, input, 16, combinational instruction memory read data for imem_addr.
REQ-007 SHALL have port instr_valid, output, 1, queue head holds a valid instruction.
REQ-008 SHALL have port instr_ready, input, 1, decode accepts head this cycle.
REQ-009 SHALL have port instr, output, 16, head instruction word.
REQ-010 SHALL have port instr_pc, output, 9, address of the head instruction.
REQ-011 SHALL have port br_taken, input, 1, redirect request from the ALU take-branch path.
REQ-012 SHALL have port br_pc, input, 9, address of the branching instruction.
REQ-013 SHALL have port br_offset, input, 9, signed PC offset.

Function
REQ-014 SHALL perform a pop when instr_valid and instr_ready are both 1 in the same cycle.
REQ-015 SHALL perform a fetch when br_taken=0 and (count<DEPTH or pop): it writes {imem_data, fetch_pc} into the queue tail and sets fetch_pc to fetch_pc+1.
REQ-016 SHALL wrap fetch_pc from 9'h1FF to 9'h000 with no flag or stall.
REQ-017 SHALL sustain one instruction per cycle when full with continuous pops, because a simultaneous pop frees the slot for the fetch.
REQ-018 SHALL hold fetch_pc, not write, and not change count when full without a pop.
REQ-019 SHALL, on br_taken=1, flush all entries (count=0), set fetch_pc=br_pc+br_offset mod 512, and inhibit that cycle's fetch.
REQ-020 SHALL give br_taken priority over a simultaneous pop: the pop is discarded.
REQ-021 SHALL latency: br_taken in cycle N gives instr_valid=1 with instr_pc=target in cycle N+2.
REQ-022 SHALL drive instr and instr_pc from the registered queue head only, with no combinational path from imem_data to instr.
REQ-023 SHALL keep instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-024 SHALL assert instr_valid iff count>0.

Reset
REQ-025 SHALL, while rst_n=0 (asserted at any time, including mid-operation), set fetch_pc=RESET_PC, count=0, pointers=0, instr_valid=0, instr=16'h0000, instr_pc=9'h000.
REQ-026 SHALL make the first fetch on the first rising edge after rst_n deasserts, with instr_valid=1 and instr_pc=RESET_PC in the following cycle.

Configuration
REQ-027 SHALL, with macro FETCH_STALL_CNT_EN defined, add output stall_cnt[15:0]: it counts cycles with rst_n=1 and instr_valid=0, saturates at 16'hFFFF, and resets to 0.
REQ-028 SHALL, without FETCH_STALL_CNT_EN, have neither the port nor its logic; all other behaviour is identical.

Structure
REQ-029 SHALL take from shared package fetch_pkg the constants PC_W=9, INSTR_W=16, FETCH_DEPTH=4 and the typedefs pc_t, instr_t, and fetch_entry_t (struct of instr_t and pc_t).
REQ-030 SHALL place the circular queue in one sub-module fetch_fifo (push, pop, flush, count, head), with PC and redirect logic in instr_fetch_unit.

Verification
REQ-031 SHALL cover reset release with imem holding addr+16'h1000 and instr_ready=1: instr_pc sequence 0,1,2,… each cycle, and instr=16'h1000+pc.
REQ-032 SHALL cover instr_ready=0 for 10 cycles: count stops at 4, imem_addr frozen at 4, and head instr_pc=0 stable; on release, pcs 0..4 arrive back-to-back.
REQ-033 SHALL cover br_taken with br_pc=9'h010 and br_offset=9'h1F8 (-8) in cycle N: queue flushed, and in cycle N+2 instr_pc=9'h008.
REQ-034 SHALL cover br_taken in the same cycle as a pop at full: the pop is discarded, and the next valid instruction is the branch target.
REQ-035 SHALL cover RESET_PC=9'h1FE: instr_pc sequence 1FE, 1FF, 000, 001.
REQ-036 SHALL cover rst_n pulsed low mid-stream with a full queue: instr_valid drops immediately (asynchronously), and the queue restarts at RESET_PC; with FETCH_STALL_CNT_EN, stall_cnt equals the counted empty cycles.
